// File: rtl/pll_scan_receiver.sv
// -----------------------------------------------------------------------------
// pll_scan_receiver
//
// Receive-side endpoint of the PLL reconfiguration scan chain. Bits arriving on
// scan_data while scan_ena is high are shifted into a frame register. A rising
// edge on pll_update either commits the frame into the shadow configuration
// registers (when exactly LEN bits were received) or rejects it. The block
// also models PLL lock behaviour so it can stand in for a real PLL during FPGA
// loopback testing.
//
// Frame layout (bit 0 is shifted first, bit LEN-1 last):
//   [144:127] head  [126:109] M  [108:91] N  [90:73] C0  [72:55] C1
//   [54:37]   C2    [36:19]   C3 [18:1]   C4 [0]     pad
//
// Ports:
//   scan_clk    in   scan chain clock, all logic rises on it
//   scan_rst    in   asynchronous active-high reset
//   scan_ena    in   shift enable, one bit accepted per cycle while high
//   scan_data   in   serial data bit, sampled when scan_ena is high
//   pll_update  in   commit request, rising edge only
//   pll_rst     in   PLL reset, active high, level-sensitive
//   head_cfg .. c4_cfg  out [17:0]  committed configuration fields
//   cfg_valid   out  one-cycle pulse when a frame is committed
//   cfg_err     out  one-cycle pulse when a commit is rejected
//   busy        out  high while a transfer is in progress
//   locked      out  modelled PLL lock
// -----------------------------------------------------------------------------
module pll_scan_receiver #(
  parameter int LEN      = 145,
  parameter int LOCK_DLY = 16
) (
  input  logic        scan_clk,
  input  logic        scan_rst,
  input  logic        scan_ena,
  input  logic        scan_data,
  input  logic        pll_update,
  input  logic        pll_rst,
  output logic [17:0] head_cfg,
  output logic [17:0] m_cfg,
  output logic [17:0] n_cfg,
  output logic [17:0] c0_cfg,
  output logic [17:0] c1_cfg,
  output logic [17:0] c2_cfg,
  output logic [17:0] c3_cfg,
  output logic [17:0] c4_cfg,
  output logic        cfg_valid,
  output logic        cfg_err,
  output logic        busy,
  output logic        locked
);

  localparam int                FIELD_W    = 18;
  localparam int                NUM_FIELDS = 8;
  localparam logic [FIELD_W-1:0] CFG_RST   = 18'h2_0000;  // bypass
  localparam logic [7:0]        LEN_CNT    = 8'(LEN);
  localparam logic [7:0]        LOCK_TGT   = 8'(LOCK_DLY);
  localparam logic [7:0]        CNT_MAX    = 8'hFF;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SHIFT  = 3'd1;
  localparam logic [2:0] ST_ARMED  = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_REJECT = 3'd4;

  // ---------------------------------------------------------------------------
  // Frame shift register. New bits enter at the top and move towards bit 0.
  // The pad position (frame bit 0) is the first bit received; after a full
  // frame it would sit below every field and never reach an output, so it is
  // allowed to fall off the end rather than being stored.
  // ---------------------------------------------------------------------------
  logic [LEN-1:1] sreg_reg;

  always_ff @(posedge scan_clk or posedge scan_rst) begin
    if (scan_rst) begin
      sreg_reg <= '0;
    end else if (scan_ena) begin
      sreg_reg <= {scan_data, sreg_reg[LEN-1:2]};
    end
  end

  // ---------------------------------------------------------------------------
  // Update edge detection. The detected edge is registered once more before
  // the FSM acts on it, which gives the two-cycle update-to-valid latency and
  // lets the bit count settle for a frame whose last bit coincides with the
  // update edge.
  // ---------------------------------------------------------------------------
  logic pll_update_d_reg;
  logic upd_rise;
  logic upd_rise_reg;

  assign upd_rise = pll_update & ~pll_update_d_reg;

  always_ff @(posedge scan_clk or posedge scan_rst) begin
    if (scan_rst) begin
      pll_update_d_reg <= 1'b0;
      upd_rise_reg     <= 1'b0;
    end else begin
      pll_update_d_reg <= pll_update;
      upd_rise_reg     <= upd_rise;
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  logic [2:0] state_reg;
  logic [2:0] state_next;
  logic [7:0] bit_cnt_reg;
  logic [7:0] bit_cnt_next;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        // An update with nothing shifted is a malformed commit.
        if (upd_rise_reg) begin
          state_next = ST_REJECT;
        end else if (scan_ena) begin
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Any registered edge seen here was sampled while still shifting.
        if (upd_rise_reg) begin
          state_next = ST_REJECT;
        end else if (!scan_ena) begin
          state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // A bit arriving together with the update overruns the frame, so
        // the update wins and the transfer is rejected.
        if (upd_rise_reg) begin
          if ((bit_cnt_reg == LEN_CNT) && !scan_ena) begin
            state_next = ST_COMMIT;
          end else begin
            state_next = ST_REJECT;
          end
        end else if (scan_ena) begin
          state_next = ST_SHIFT;
        end
      end
      ST_COMMIT: state_next = ST_IDLE;
      ST_REJECT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Bit counter: starts at 1 on the first bit of a transfer, continues across
  // ARMED gaps so split frames are legal, saturates, and is cleared whenever
  // the transfer terminates. Bits shifted during the single COMMIT/REJECT
  // cycle are not part of any transfer and are not counted.
  always_comb begin
    bit_cnt_next = bit_cnt_reg;
    if ((state_next == ST_COMMIT) || (state_next == ST_REJECT)) begin
      bit_cnt_next = '0;
    end else if (scan_ena) begin
      if (state_reg == ST_IDLE) begin
        bit_cnt_next = 8'd1;
      end else if ((state_reg == ST_SHIFT) || (state_reg == ST_ARMED)) begin
        if (bit_cnt_reg != CNT_MAX) begin
          bit_cnt_next = bit_cnt_reg + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge scan_clk or posedge scan_rst) begin
    if (scan_rst) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
    end
  end

  // Status outputs are registered from the next state so each pulse lines up
  // exactly with the cycle the FSM spends in COMMIT or REJECT.
  logic cfg_valid_reg;
  logic cfg_err_reg;
  logic busy_reg;

  always_ff @(posedge scan_clk or posedge scan_rst) begin
    if (scan_rst) begin
      cfg_valid_reg <= 1'b0;
      cfg_err_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      cfg_valid_reg <= (state_next == ST_COMMIT);
      cfg_err_reg   <= (state_next == ST_REJECT);
      busy_reg      <= (state_next == ST_SHIFT) || (state_next == ST_ARMED);
    end
  end

  assign cfg_valid = cfg_valid_reg;
  assign cfg_err   = cfg_err_reg;
  assign busy      = busy_reg;

  // ---------------------------------------------------------------------------
  // Shadow configuration registers. Field 0 is head, field 7 is C4; field k
  // occupies the 18 bits directly below field k-1. They load on the edge that
  // enters COMMIT so the new values appear together with cfg_valid.
  // ---------------------------------------------------------------------------
  logic [FIELD_W-1:0] cfg_reg [NUM_FIELDS];
  logic               commit_load;

  assign commit_load = (state_next == ST_COMMIT);

  generate
    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
      always_ff @(posedge scan_clk or posedge scan_rst) begin
        if (scan_rst) begin
          cfg_reg[gi] <= CFG_RST;
        end else if (commit_load) begin
          cfg_reg[gi] <= sreg_reg[LEN-1-gi*FIELD_W -: FIELD_W];
        end
      end
    end
  endgenerate

  assign head_cfg = cfg_reg[0];
  assign m_cfg    = cfg_reg[1];
  assign n_cfg    = cfg_reg[2];
  assign c0_cfg   = cfg_reg[3];
  assign c1_cfg   = cfg_reg[4];
  assign c2_cfg   = cfg_reg[5];
  assign c3_cfg   = cfg_reg[6];
  assign c4_cfg   = cfg_reg[7];

  // ---------------------------------------------------------------------------
  // Lock model. The counter runs from pll_rst deassertion and parks at
  // LOCK_DLY, where lock is asserted and held. pll_rst also masks the output
  // directly so lock drops as soon as reset is applied, not one edge later.
  // Configuration commits never touch this logic.
  // ---------------------------------------------------------------------------
  logic [7:0] lock_cnt_reg;
  logic       lock_reg;

  always_ff @(posedge scan_clk or posedge scan_rst) begin
    if (scan_rst) begin
      lock_cnt_reg <= '0;
      lock_reg     <= 1'b0;
    end else if (pll_rst) begin
      lock_cnt_reg <= '0;
      lock_reg     <= 1'b0;
    end else if (lock_cnt_reg != LOCK_TGT) begin
      lock_cnt_reg <= lock_cnt_reg + 8'd1;
      lock_reg     <= ((lock_cnt_reg + 8'd1) == LOCK_TGT);
    end else begin
      lock_reg     <= 1'b1;
    end
  end

  assign locked = lock_reg & ~pll_rst;

endmodule

// File: tb/tb_pll_scan_receiver.sv
// -----------------------------------------------------------------------------
// tb_pll_scan_receiver
//
// Directed self-checking bench for pll_scan_receiver. Inputs are driven and
// outputs sampled 1 ns after each rising edge of scan_clk.
// -----------------------------------------------------------------------------
module tb_pll_scan_receiver;

  logic        scan_clk;
  logic        scan_rst;
  logic        scan_ena;
  logic        scan_data;
  logic        pll_update;
  logic        pll_rst;
  logic [17:0] head_cfg;
  logic [17:0] m_cfg;
  logic [17:0] n_cfg;
  logic [17:0] c0_cfg;
  logic [17:0] c1_cfg;
  logic [17:0] c2_cfg;
  logic [17:0] c3_cfg;
  logic [17:0] c4_cfg;
  logic        cfg_valid;
  logic        cfg_err;
  logic        busy;
  logic        locked;

  int checks   = 0;
  int failures = 0;

  pll_scan_receiver #(
    .LEN      (145),
    .LOCK_DLY (16)
  ) dut (
    .scan_clk   (scan_clk),
    .scan_rst   (scan_rst),
    .scan_ena   (scan_ena),
    .scan_data  (scan_data),
    .pll_update (pll_update),
    .pll_rst    (pll_rst),
    .head_cfg   (head_cfg),
    .m_cfg      (m_cfg),
    .n_cfg      (n_cfg),
    .c0_cfg     (c0_cfg),
    .c1_cfg     (c1_cfg),
    .c2_cfg     (c2_cfg),
    .c3_cfg     (c3_cfg),
    .c4_cfg     (c4_cfg),
    .cfg_valid  (cfg_valid),
    .cfg_err    (cfg_err),
    .busy       (busy),
    .locked     (locked)
  );

  initial scan_clk = 1'b0;
  always #5 scan_clk = ~scan_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge scan_clk);
    #1;
  endtask

  function automatic logic [144:0] build(input logic [17:0] h, input logic [17:0] m,
                                         input logic [17:0] n, input logic [17:0] c0,
                                         input logic [17:0] c1, input logic [17:0] c2,
                                         input logic [17:0] c3, input logic [17:0] c4);
    return {h, m, n, c0, c1, c2, c3, c4, 1'b0};
  endfunction

  // Shift frame bits first..first+count-1, lowest index first.
  task automatic send_bits(input logic [144:0] f, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      scan_ena  = 1'b1;
      scan_data = f[i];
      tick();
    end
    scan_ena  = 1'b0;
    scan_data = 1'b0;
  endtask

  task automatic chk_fields(input string tag, input logic [144:0] f);
    chk({tag, "_head"}, head_cfg, f[144:127]);
    chk({tag, "_m"},    m_cfg,    f[126:109]);
    chk({tag, "_n"},    n_cfg,    f[108:91]);
    chk({tag, "_c0"},   c0_cfg,   f[90:73]);
    chk({tag, "_c1"},   c1_cfg,   f[72:55]);
    chk({tag, "_c2"},   c2_cfg,   f[54:37]);
    chk({tag, "_c3"},   c3_cfg,   f[36:19]);
    chk({tag, "_c4"},   c4_cfg,   f[18:1]);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_head"},  head_cfg,  18'h20000);
    chk({tag, "_m"},     m_cfg,     18'h20000);
    chk({tag, "_n"},     n_cfg,     18'h20000);
    chk({tag, "_c0"},    c0_cfg,    18'h20000);
    chk({tag, "_c1"},    c1_cfg,    18'h20000);
    chk({tag, "_c2"},    c2_cfg,    18'h20000);
    chk({tag, "_c3"},    c3_cfg,    18'h20000);
    chk({tag, "_c4"},    c4_cfg,    18'h20000);
    chk({tag, "_valid"}, cfg_valid, 1'b0);
    chk({tag, "_err"},   cfg_err,   1'b0);
    chk({tag, "_busy"},  busy,      1'b0);
    chk({tag, "_lock"},  locked,    1'b0);
  endtask

  // Raise pll_update right after the last shifted bit; the result pulse is
  // expected on the second edge and only there.
  task automatic do_update(input string tag, input logic exp_valid, input logic exp_err);
    pll_update = 1'b1;
    tick();
    chk({tag, "_valid_e1"}, cfg_valid, 1'b0);
    chk({tag, "_err_e1"},   cfg_err,   1'b0);
    chk({tag, "_busy_e1"},  busy,      1'b1);
    tick();
    chk({tag, "_valid_e2"}, cfg_valid, exp_valid);
    chk({tag, "_err_e2"},   cfg_err,   exp_err);
    chk({tag, "_busy_e2"},  busy,      1'b0);
    tick();
    chk({tag, "_valid_e3"}, cfg_valid, 1'b0);
    chk({tag, "_err_e3"},   cfg_err,   1'b0);
    pll_update = 1'b0;
    $display("txn %s: update valid=%0b err=%0b", tag, cfg_valid, cfg_err);
  endtask

  logic [144:0] frame_a;
  logic [144:0] frame_b;
  logic [144:0] frame_c;
  int           valid_cnt;
  int           err_cnt;

  initial begin
    scan_rst   = 1'b1;
    scan_ena   = 1'b0;
    scan_data  = 1'b0;
    pll_update = 1'b0;
    pll_rst    = 1'b0;

    frame_a = build(18'h06C01, 18'h00A05, 18'h20000, 18'h00202,
                    18'h00404, 18'h20000, 18'h20000, 18'h20000);
    frame_b = build(18'h11111, 18'h02222, 18'h03333, 18'h04444,
                    18'h05555, 18'h06666, 18'h07777, 18'h08888);
    frame_c = build(18'h3FFFF, 18'h00001, 18'h2AAAA, 18'h15555,
                    18'h00100, 18'h12345, 18'h0ABCD, 18'h30003);

    // Reset state
    tick();
    tick();
    chk_reset_outputs("rst");
    scan_rst = 1'b0;
    tick();
    $display("txn reset: released");

    // Full frame commit
    send_bits(frame_a, 0, 1);
    chk("a_busy_first_bit", busy, 1'b1);
    send_bits(frame_a, 1, 144);
    do_update("a", 1'b1, 1'b0);
    chk_fields("a", frame_a);

    // 144-bit frame is rejected, fields keep frame A
    send_bits(frame_b, 0, 144);
    do_update("short", 1'b0, 1'b1);
    chk_fields("short_keep", frame_a);

    // 146-bit frame is rejected, then a correct frame commits
    send_bits(frame_b, 0, 1);
    send_bits(frame_b, 0, 145);
    do_update("long", 1'b0, 1'b1);
    chk_fields("long_keep", frame_a);
    send_bits(frame_b, 0, 145);
    do_update("b", 1'b1, 1'b0);
    chk_fields("b", frame_b);

    // Split frame: 100 bits, 5-cycle gap, 45 bits
    send_bits(frame_c, 0, 100);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("split_gap_busy", busy, 1'b1);
    end
    send_bits(frame_c, 100, 45);
    do_update("split", 1'b1, 1'b0);
    chk_fields("split", frame_c);

    // Update held high for 10 cycles gives exactly one commit
    send_bits(frame_a, 0, 145);
    pll_update = 1'b1;
    valid_cnt  = 0;
    err_cnt    = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 10) pll_update = 1'b0;
      tick();
      if (cfg_valid) valid_cnt++;
      if (cfg_err) err_cnt++;
    end
    chk("held_valid_count", valid_cnt, 1);
    chk("held_err_count", err_cnt, 0);
    chk_fields("held", frame_a);
    $display("txn held: valid pulses=%0d err pulses=%0d", valid_cnt, err_cnt);

    // Update while still shifting is rejected
    send_bits(frame_b, 0, 20);
    scan_ena   = 1'b1;
    pll_update = 1'b1;
    tick();
    chk("shift_upd_err_e1", cfg_err, 1'b0);
    chk("shift_upd_busy_e1", busy, 1'b1);
    tick();
    chk("shift_upd_err_e2", cfg_err, 1'b1);
    chk("shift_upd_valid_e2", cfg_valid, 1'b0);
    scan_ena = 1'b0;
    tick();
    chk("shift_upd_err_e3", cfg_err, 1'b0);
    chk("shift_upd_busy_e3", busy, 1'b0);
    pll_update = 1'b0;
    chk_fields("shift_upd_keep", frame_a);
    $display("txn shift_upd: rejected");

    // Lock model
    chk("lock_before", locked, 1'b1);
    pll_rst = 1'b1;
    #1;
    chk("lock_drop_immediate", locked, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lock_in_rst", locked, 1'b0);
    end
    pll_rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("lock_wait_%0d", i), locked, (i == 16) ? 1'b1 : 1'b0);
    end
    tick();
    chk("lock_hold", locked, 1'b1);
    chk_fields("lock_cfg_keep", frame_a);
    $display("txn lock: relocked");

    // scan_rst mid-frame, then a full frame commits
    send_bits(frame_c, 0, 70);
    scan_rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    tick();
    scan_rst = 1'b0;
    tick();
    send_bits(frame_b, 0, 145);
    do_update("after_rst", 1'b1, 1'b0);
    chk_fields("after_rst", frame_b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
